// File: rtl/iter_shifter.sv
// Iterative shift unit: one bit position per clock, four modes, valid/ready on both sides.
// Result, carry and zero flag are held in DONE until the consumer takes them.
module iter_shifter #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROL = 2'b11;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] data_reg, data_next;
   logic [SHW-1:0]   count_reg, count_next;
   logic [1:0]       mode_reg, mode_next;
   logic             carry_reg, carry_next;

   logic [WIDTH-1:0] step_left, step_right, step_data;
   logic             fill_left, fill_right, dir_right, step_carry;

   // SRL (01) and SRA (10) move right; SLL (00) and ROL (11) move left.
   assign dir_right  = mode_reg[1] ^ mode_reg[0];
   assign fill_left  = (mode_reg == MODE_ROL) ? data_reg[WIDTH-1] : 1'b0;
   assign fill_right = (mode_reg == MODE_SRA) ? data_reg[WIDTH-1] : 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
         if (gi == 0) begin : g_lsb
            assign step_left[gi] = fill_left;
         end else begin : g_lsb_n
            assign step_left[gi] = data_reg[gi-1];
         end
         if (gi == WIDTH-1) begin : g_msb
            assign step_right[gi] = fill_right;
         end else begin : g_msb_n
            assign step_right[gi] = data_reg[gi+1];
         end
      end
   endgenerate

   assign step_data  = dir_right ? step_right : step_left;
   assign step_carry = dir_right ? data_reg[0] : data_reg[WIDTH-1];

   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      count_next = count_reg;
      mode_next  = mode_reg;
      carry_next = carry_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               data_next  = in_data;
               count_next = in_amt;
               mode_next  = in_mode;
               carry_next = 1'b0;
               state_next = (in_amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            data_next  = step_data;
            carry_next = step_carry;
            count_next = count_reg - 1'b1;
            if (count_reg == SHW'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // A new operand offered here waits for IDLE; there is no bypass.
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_reg <= IDLE;
         data_reg  <= '0;
         count_reg <= '0;
         mode_reg  <= '0;
         carry_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         count_reg <= count_next;
         mode_reg  <= mode_next;
         carry_reg <= carry_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg == SHIFT) || (state_reg == DONE);
   assign out_data  = data_reg;
   assign out_carry = carry_reg;
   assign out_zero  = (data_reg == '0);

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Multi-cycle, parametrised shift unit for the stack processor ALU path; replaces the fixed 12-to-13-bit shift-left-by-one wiring.
- Shifts one bit position per clock, so area stays small at any word width.
- Supports four modes, variable shift amount, carry-out and zero flag.
- Uses a valid/ready handshake on input and output so the control unit can stall on it.

Parameters:
- WIDTH, 16, data word width in bits (≥2).
- SHW, $clog2(WIDTH), width of the shift-amount field; amount range 0..WIDTH-1.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid; a transfer occurs on an edge where in_valid && in_ready.
- in_ready  output  1  unit idle and able to accept operands.
- in_data  input  WIDTH  operand to shift.
- in_amt  input  SHW  shift distance.
- in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts; a transfer occurs on an edge where out_valid && out_ready.
- out_data  output  WIDTH  shifted result.
- out_carry  output  1  last bit shifted or rotated out; 0 when amt=0.
- out_zero  output  1  out_data == 0.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on reset and has priority over all other inputs.
- Reset state (including reset mid-operation): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_carry=0, busy=0. Any in-flight operation is discarded.
- States:
  - IDLE: in_ready=1.
  - SHIFT: busy=1, in_ready=0.
  - DONE: out_valid=1, busy=1, in_ready=0.
- Transitions:
  - IDLE + accept, amt≠0: latch data into the shift register, count=amt, mode, carry=0, go to SHIFT.
  - IDLE + accept, amt=0: latch data unchanged, carry=0, go directly to DONE.
  - SHIFT: each edge performs one 1-bit step and decrements count. On the edge where count goes 1→0, go to DONE.
  - DONE + out_ready: go to IDLE. DONE with out_ready=0 holds out_data, out_carry and out_zero stable.
- Per-step operations (r = register):
  - SLL: carry=r[W-1]; r={r[W-2:0],0}.
  - SRL: carry=r[0]; r={0,r[W-1:1]}.
  - SRA: carry=r[0]; r={r[W-1],r[W-1:1]}.
  - ROL: carry=r[W-1]; r={r[W-2:0],r[W-1]}.
- Latency: with accept on edge E, out_valid is high after edge E+amt. Minimum 1 cycle (amt=0), maximum WIDTH cycles.
- Throughput: one operation per amt+2 cycles, with no overlap. in_ready is 0 in SHIFT and DONE, and in_valid is ignored there.
- Input sampling: in_data, in_amt and in_mode are sampled only on the accept edge; later changes have no effect.
- out_zero is combinational from the result register.
- Outputs in SHIFT are don't-care for the consumer, but out_data shows the intermediate register (useful for debug).
- Simultaneous out_ready and in_valid in DONE: only the output transfer happens. The new input is accepted on a later IDLE edge; there is no bypass.
- The amount field cannot exceed WIDTH-1 by construction, so no saturation logic is needed.

Test Plan:
- Reset during SHIFT: SRL 0x8000 amt=15, assert reset at cycle 5 -> next edge in_ready=1, out_valid=0, busy=0, out_data=0. A subsequent op completes normally.
- SLL 0x0FFF amt=1 -> out_data=0x1FFE, carry=0, zero=0, out_valid after 2 cycles (1-bit successor check). SLL 0xC000 amt=1 -> 0x8000, carry=1.
- SRA 0x8001 amt=3 -> 0xF000, carry=0. SRL 0x00F0 amt=5 -> 0x0007, carry=1. SRL 0x0001 amt=1 -> 0x0000, carry=1, zero=1.
- ROL 0xF001 amt=4 -> 0x001F, carry=1, latency 4 cycles after the accept edge. Any mode with amt=0 on 0x1234 -> 0x1234, carry=0, out_valid one edge after accept.
- Backpressure: complete SLL 0x0003 amt=2 with out_ready=0 for 6 cycles -> out_data=0x000C held stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> IDLE next edge.
- Back-to-back: in_valid held high across 3 ops with out_ready=1 -> exactly 3 results in order, each spaced amt+2 cycles. Also WIDTH=8 instance: SRA 0x80 amt=7 -> 0xFF, carry=0.
